m_clk_div: RTL and testbench

- Programmable integer clock divider that generates a glitch-free, flop-driven divided clock level and a matching single-cycle tick.
- Sits directly upstream of the clock NAND/gating cell stage and feeds its data input.
- Ratio changes and start/stop take effect only on full-period boundaries, so downstream clock logic never sees a truncated high or low phase.

---
 rtl/m_clk_div.sv | 104 ++++++++++
 tb/tb_m_clk_div.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_clk_div.sv
// Programmable integer clock divider: flop-driven divided clock level plus a
// one-cycle tick, with divisor and run/stop changes held to period boundaries.
module m_clk_div #(
   parameter int DIV_W     = 8,
   parameter int RESET_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_en,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             div_update,
   output logic             div_clk,
   output logic             div_tick,
   output logic             upd_ack,
   output logic             running
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [DIV_W-1:0] RESET_N = DIV_W'(RESET_DIV);
   localparam logic [DIV_W-1:0] MIN_N   = DIV_W'(2);

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] n_cur;
   logic [DIV_W-1:0] pending;
   logic             pend_vld;

   logic [DIV_W-1:0] ratio_clamped;
   logic [DIV_W-1:0] high_len;
   logic [DIV_W-1:0] cnt_inc;
   logic             boundary;

   // High phase is ceil(N/2); computed without widening so N = 2^DIV_W-1 is safe.
   always_comb begin
      ratio_clamped = (div_ratio < MIN_N) ? MIN_N : div_ratio;
      high_len      = (n_cur >> 1) + {{(DIV_W-1){1'b0}}, n_cur[0]};
      cnt_inc       = cnt + 1'b1;
      boundary      = (cnt == n_cur - 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         n_cur    <= RESET_N;
         pending  <= RESET_N;
         pend_vld <= 1'b0;
         div_clk  <= 1'b0;
         div_tick <= 1'b0;
         upd_ack  <= 1'b0;
         running  <= 1'b0;
      end else begin
         div_tick <= 1'b0;
         upd_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (div_update) begin
                  n_cur   <= ratio_clamped;
                  upd_ack <= 1'b1;
               end
               if (div_en) begin
                  state    <= RUN;
                  cnt      <= '0;
                  div_clk  <= 1'b1;
                  div_tick <= 1'b1;
                  running  <= 1'b1;
               end
            end
            RUN: begin
               if (boundary) begin
                  // A same-cycle request overrides anything still pending.
                  if (div_update) begin
                     n_cur    <= ratio_clamped;
                     pend_vld <= 1'b0;
                     upd_ack  <= 1'b1;
                  end else if (pend_vld) begin
                     n_cur    <= pending;
                     pend_vld <= 1'b0;
                     upd_ack  <= 1'b1;
                  end
                  cnt <= '0;
                  if (div_en) begin
                     div_clk  <= 1'b1;
                     div_tick <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     div_clk <= 1'b0;
                     running <= 1'b0;
                  end
               end else begin
                  cnt     <= cnt_inc;
                  div_clk <= (cnt_inc < high_len);
                  if (div_update) begin
                     pending  <= ratio_clamped;
                     pend_vld <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m_clk_div.sv
// Randomised bench for m_clk_div; expected waveform comes from a period-queue
// model that builds each whole period of div_clk values when the period starts.
module tb_m_clk_div;

   localparam int DIV_W     = 8;
   localparam int RESET_DIV = 2;

   logic             clk;
   logic             rst_n;
   logic             div_en;
   logic [DIV_W-1:0] div_ratio;
   logic             div_update;
   logic             div_clk;
   logic             div_tick;
   logic             upd_ack;
   logic             running;

   int compare_count;
   int fail_count;

   bit m_run;
   int m_n;
   int m_pend;
   bit period_q[$];
   bit exp_clk;
   bit exp_tick;
   bit exp_ack;

   m_clk_div #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .div_en     (div_en),
      .div_ratio  (div_ratio),
      .div_update (div_update),
      .div_clk    (div_clk),
      .div_tick   (div_tick),
      .upd_ack    (upd_ack),
      .running    (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      compare_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_run    = 1'b0;
      m_n      = RESET_DIV;
      m_pend   = -1;
      period_q.delete();
      exp_clk  = 1'b0;
      exp_tick = 1'b0;
      exp_ack  = 1'b0;
   endtask

   // Lay out one whole period: ceil(N/2) high cycles, then the low cycles.
   task automatic startPeriod();
      period_q.delete();
      for (int i = 0; i < m_n; i++) period_q.push_back(i < (m_n + 1) / 2);
      exp_clk  = period_q.pop_front();
      exp_tick = 1'b1;
   endtask

   task automatic modelStep(input bit en, input bit upd, input int ratio);
      int c;
      c = (ratio < 2) ? 2 : ratio;
      exp_tick = 1'b0;
      exp_ack  = 1'b0;
      if (!m_run) begin
         if (upd) begin
            m_n     = c;
            exp_ack = 1'b1;
         end
         if (en) begin
            m_run = 1'b1;
            startPeriod();
         end else begin
            exp_clk = 1'b0;
         end
      end else if (period_q.size() == 0) begin
         if (upd) begin
            m_n     = c;
            m_pend  = -1;
            exp_ack = 1'b1;
         end else if (m_pend >= 0) begin
            m_n     = m_pend;
            m_pend  = -1;
            exp_ack = 1'b1;
         end
         if (en) begin
            startPeriod();
         end else begin
            m_run   = 1'b0;
            exp_clk = 1'b0;
         end
      end else begin
         if (upd) m_pend = c;
         exp_clk = period_q.pop_front();
      end
   endtask

   task automatic applyStimulus(input bit en, input bit upd, input int ratio);
      div_en     = en;
      div_update = upd;
      div_ratio  = DIV_W'(ratio);
      @(posedge clk);
      modelStep(en, upd, ratio);
      #1;
      checkOutput("div_clk", div_clk, exp_clk);
      checkOutput("div_tick", div_tick, exp_tick);
      checkOutput("upd_ack", upd_ack, exp_ack);
      checkOutput("running", running, m_run);
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      modelReset();
      #2;
      checkOutput("rst_div_clk", div_clk, 1'b0);
      checkOutput("rst_div_tick", div_tick, 1'b0);
      checkOutput("rst_upd_ack", upd_ack, 1'b0);
      checkOutput("rst_running", running, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic runCycles(input int n, input bit en);
      for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 0);
   endtask

   // Drop div_en and wait out the current period, bounded.
   task automatic stopAndWait();
      int budget;
      budget = 0;
      applyStimulus(1'b0, 1'b0, 0);
      while (m_run && budget < 300) begin
         applyStimulus(1'b0, 1'b0, 0);
         budget++;
      end
      checkOutput("stop_timeout", running, 1'b0);
   endtask

   initial begin
      compare_count = 0;
      fail_count    = 0;
      rst_n         = 1'b0;
      div_en        = 1'b0;
      div_update    = 1'b0;
      div_ratio     = '0;
      modelReset();
      #12;
      applyReset();

      $display("[TB] default divisor start-up");
      runCycles(2, 1'b0);
      runCycles(9, 1'b1);
      stopAndWait();

      $display("[TB] N=5 loaded in IDLE");
      applyStimulus(1'b0, 1'b1, 5);
      runCycles(16, 1'b1);
      stopAndWait();

      $display("[TB] mid-period update 4 -> 6");
      applyStimulus(1'b0, 1'b1, 4);
      applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 6);
      runCycles(14, 1'b1);

      $display("[TB] two updates, second on the boundary");
      // Now on a 6-period; step to its last cycle while parking 7 as pending.
      while (period_q.size() != 3) applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 7);
      while (period_q.size() != 0) applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 3);
      runCycles(10, 1'b1);

      $display("[TB] clamp of ratios 0 and 1");
      applyStimulus(1'b1, 1'b1, 0);
      runCycles(6, 1'b1);
      applyStimulus(1'b1, 1'b1, 1);
      runCycles(6, 1'b1);

      $display("[TB] stop request and short en glitch with N=6");
      applyStimulus(1'b1, 1'b1, 6);
      while (period_q.size() != 0) applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 0);
      runCycles(2, 1'b0);
      runCycles(10, 1'b1);
      stopAndWait();
      applyStimulus(1'b1, 1'b1, 6);
      applyStimulus(1'b0, 1'b0, 0);
      runCycles(8, 1'b0);

      $display("[TB] reset during high phase with pending update");
      applyStimulus(1'b0, 1'b1, 8);
      applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 9);
      applyReset();
      runCycles(8, 1'b1);
      stopAndWait();

      $display("[TB] randomised run");
      for (int i = 0; i < 3000; i++) begin
         bit en;
         bit upd;
         int ratio;
         en    = ($urandom_range(0, 15) != 0);
         upd   = ($urandom_range(0, 9) == 0);
         ratio = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
         if ($urandom_range(0, 499) == 0) applyReset();
         else applyStimulus(en, upd, ratio);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
